uart_tx_ctrl: RTL and testbench
===============================

# uart_tx_ctrl

UART transmitter on the FPGA side of the serial link, the opposite direction to the FPGA's UART receiver. Bytes come in over a valid/ready handshake, are buffered in a small FIFO, and are serialized as 8N1 frames (optionally 8E1) on `uart_tx`. Frames are sent LSB-first. Queued bytes go out back-to-back with no idle gap. Inside `FPGA_TOP`, `uart_tx` connects to the pad that the testbench loops back and monitors.

## Interface
- `CLKS_PER_BIT`, 16: `clk_in` cycles per bit period; legal range ≥ 2.
- `FIFO_DEPTH`, 4: byte FIFO entries; power of two, ≥ 2.
- `clk_in`  in  1  system clock; all logic on rising edge.
- `arstn`  in  1  reset, synchronous, active-low.
- `tx_data`  in  8  byte to send.
- `tx_valid`  in  1  `tx_data` valid.
- `tx_ready`  out  1  FIFO can accept; transfer on `tx_valid & tx_ready`.
- `uart_tx`  out  1  serial line, registered, idle high.
- `tx_busy`  out  1  FSM not in IDLE.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  entries currently held.

## Operation
- Reset (`arstn`=0 at an edge) has these effects:
  - `uart_tx`=1, `tx_busy`=0, `fifo_level`=0.
  - FSM goes to IDLE; baud counter and bit index are cleared.
  - `tx_ready` is forced 0 while `arstn` is low.
- `tx_ready` = `arstn` & (`fifo_level` != `FIFO_DEPTH`). It is combinational from the registered count.
  - A pop in the same cycle never frees space for a write when full; there is no bypass.
- FIFO push and pop in the same cycle leave `fifo_level` unchanged. Pointers wrap modulo `FIFO_DEPTH`.
- FSM states: IDLE, START, DATA, PARITY (only with macro), STOP.
  - IDLE: if `fifo_level`>0, pop the head into the 8-bit shift register, clear the baud counter, go to START. Otherwise stay.
  - START: drive 0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: drive shift[0] for one bit period, then shift right and increment the index. After index 7 completes, go to PARITY (macro on) or STOP.
  - PARITY: drive the even-parity bit (XOR of the 8 data bits) for one bit period, then go to STOP.
  - STOP: drive 1 for one bit period.
    - At its last cycle, if `fifo_level`>0, pop and go directly to START (back-to-back).
    - Otherwise go to IDLE.
- Baud counter counts 0..`CLKS_PER_BIT`-1. The state/bit advance happens on the edge where counter = `CLKS_PER_BIT`-1.
- `tx_data` is sampled only at push; later changes on the input have no effect on queued bytes.

## Timing
- Byte accepted at edge E into an empty FIFO with the FSM in IDLE:
  - Pop happens and `uart_tx` goes 0 after edge E+1.
  - `fifo_level` reads 1 after E and 0 after E+1.
- Frame length is 10×`CLKS_PER_BIT` cycles (11× with parity). `tx_busy`=1 from E+1 to the end of the final STOP.
- Back-to-back frames: the next start bit begins on the cycle right after the last STOP cycle, with no extra idle cycle.
- Reset mid-frame: `uart_tx`=1 after the reset edge, and the frame is truncated. Queued bytes are discarded. The first push after release behaves as from power-up.
- A push while full is ignored: `tx_ready`=0, so no transfer occurs.

## Configuration
- Macro `UART_TX_PARITY_EN`:
  - Defined: PARITY state is compiled in; frames are 8E1, 11 bit periods.
  - Undefined: no PARITY state or parity logic; frames are 8N1, 10 bit periods.

## Test plan
- Single byte, `CLKS_PER_BIT`=4, push 0xA5 at edge E.
  - From E+1, `uart_tx` = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total).
  - Then `uart_tx` idles at 1 and `tx_busy` falls at E+41.
- FIFO fill, `FIFO_DEPTH`=4, push 0x01..0x06 on consecutive cycles.
  - 0x01 pops at once; 0x02..0x05 fill the FIFO to `fifo_level`=4.
  - `tx_ready`=0 holds 0x06 until the pop of 0x02 at the end of frame 1.
  - Frames are contiguous, with a start bit every 40 cycles.
- Simultaneous push and pop at the STOP→START boundary with `fifo_level`=2: `fifo_level` stays 2 and the byte order is preserved.
- Reset mid-frame: drop `arstn` 10 cycles into the frame of 0x3C with 2 more bytes queued.
  - `uart_tx`=1, `fifo_level`=0, `tx_busy`=0 after the edge.
  - No further frames are sent.
- `UART_TX_PARITY_EN` defined, push 0x07: parity bit = 1; the frame is 0,1,1,1,0,0,0,0,0,1,1 (44 cycles at `CLKS_PER_BIT`=4).
- `CLKS_PER_BIT`=2, push 0xFF: start bit 2 cycles low, then 18 cycles high. The next push starts immediately after STOP.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl
//
// UART transmitter: bytes arrive over a valid/ready handshake, are queued in a
// small FIFO and serialized LSB-first as 8N1 frames on uart_tx. Queued bytes
// are sent back-to-back with no idle gap between frames.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   -> an even-parity bit is sent after the data bits (8E1 frames)
//   undefined -> no parity state or logic (8N1 frames)
//
// Parameters
//   CLKS_PER_BIT : clk_in cycles per bit period (>= 2)
//   FIFO_DEPTH   : byte FIFO entries (power of two, >= 2)
//
// Ports
//   clk_in     in   system clock, all logic on the rising edge
//   arstn      in   synchronous active-low reset
//   tx_data    in   byte to send, captured only when pushed
//   tx_valid   in   tx_data valid
//   tx_ready   out  FIFO can accept; a byte moves on tx_valid & tx_ready
//   uart_tx    out  serial line, registered, idles high
//   tx_busy    out  high while a frame is being sent
//   fifo_level out  number of bytes currently queued
// -----------------------------------------------------------------------------
module uart_tx_ctrl #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk_in,
    input  logic                        arstn,
    input  logic [7:0]                  tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        uart_tx,
    output logic                        tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [LVL_W-1:0] LVL_ZERO = {LVL_W{1'b0}};
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Even parity: the bit that makes the total count of ones even.
    function automatic logic parity8(input logic [7:0] d);
        return ^d;
    endfunction
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd4
    } state_t;
`endif

    state_t             state_r;
    state_t             state_next_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_next_s;
    logic [2:0]         idx_r;
    logic [2:0]         idx_next_s;
    logic [7:0]         shift_r;
    logic [7:0]         shift_next_s;
    logic               line_r;
    logic               line_next_s;
    logic               busy_r;
    logic [7:0]         mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [LVL_W-1:0]   level_r;
    logic [LVL_W-1:0]   level_next_s;
    logic               push_s;
    logic               pop_s;
    logic               bit_end_s;
    logic               have_data_s;
    logic [7:0]         head_s;
`ifdef UART_TX_PARITY_EN
    logic               parity_r;
    logic               parity_next_s;
`endif

    // No bypass: space only exists when the registered count says so.
    assign tx_ready    = arstn & (level_r != LVL_FULL);
    assign push_s      = tx_valid & tx_ready;
    assign have_data_s = (level_r != LVL_ZERO);
    assign head_s      = mem_r[rd_ptr_r];
    assign bit_end_s   = (cnt_r == CNT_LAST);

    assign uart_tx    = line_r;
    assign tx_busy    = busy_r;
    assign fifo_level = level_r;

    // Next-state, pop request and next line value of the frame sequencer.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        idx_next_s   = idx_r;
        shift_next_s = shift_r;
        pop_s        = 1'b0;
        line_next_s  = 1'b1;
`ifdef UART_TX_PARITY_EN
        parity_next_s = parity_r;
`endif

        case (state_r)
            ST_IDLE: begin
                if (have_data_s) begin
                    pop_s        = 1'b1;
                    shift_next_s = head_s;
                    cnt_next_s   = CNT_ZERO;
                    state_next_s = ST_START;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    cnt_next_s   = CNT_ZERO;
                    idx_next_s   = 3'd0;
                    state_next_s = ST_DATA;
                end else begin
                    cnt_next_s = cnt_r + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    cnt_next_s   = CNT_ZERO;
                    shift_next_s = {1'b0, shift_r[7:1]};
                    if (idx_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next_s = ST_PARITY;
`else
                        state_next_s = ST_STOP;
`endif
                    end else begin
                        idx_next_s = idx_r + 3'd1;
                    end
                end else begin
                    cnt_next_s = cnt_r + CNT_ONE;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end_s) begin
                    cnt_next_s   = CNT_ZERO;
                    state_next_s = ST_STOP;
                end else begin
                    cnt_next_s = cnt_r + CNT_ONE;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end_s) begin
                    cnt_next_s = CNT_ZERO;
                    // Chain straight into the next start bit when data waits.
                    if (have_data_s) begin
                        pop_s        = 1'b1;
                        shift_next_s = head_s;
                        state_next_s = ST_START;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    cnt_next_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = CNT_ZERO;
                idx_next_s   = 3'd0;
            end
        endcase

`ifdef UART_TX_PARITY_EN
        // Parity is latched from the whole byte before shifting destroys it.
        if (pop_s) begin
            parity_next_s = parity8(head_s);
        end else begin
            parity_next_s = parity_r;
        end
`endif

        // Line value is derived from the next state so uart_tx is a register.
        case (state_next_s)
            ST_IDLE:   line_next_s = 1'b1;
            ST_START:  line_next_s = 1'b0;
            ST_DATA:   line_next_s = shift_next_s[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: line_next_s = parity_next_s;
`endif
            ST_STOP:   line_next_s = 1'b1;
            default:   line_next_s = 1'b1;
        endcase
    end

    // FIFO occupancy: simultaneous push and pop leave the count unchanged.
    always_comb begin
        level_next_s = level_r;
        case ({push_s, pop_s})
            2'b10:   level_next_s = level_r + LVL_ONE;
            2'b01:   level_next_s = level_r - LVL_ONE;
            default: level_next_s = level_r;
        endcase
    end

    // Sequencer, FIFO pointers and registered outputs.
    always_ff @(posedge clk_in) begin
        if (!arstn) begin
            state_r  <= ST_IDLE;
            cnt_r    <= CNT_ZERO;
            idx_r    <= 3'd0;
            shift_r  <= 8'h00;
            line_r   <= 1'b1;
            busy_r   <= 1'b0;
            level_r  <= LVL_ZERO;
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
`ifdef UART_TX_PARITY_EN
            parity_r <= 1'b0;
`endif
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            idx_r   <= idx_next_s;
            shift_r <= shift_next_s;
            line_r  <= line_next_s;
            busy_r  <= (state_next_s != ST_IDLE);
            level_r <= level_next_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
`ifdef UART_TX_PARITY_EN
            parity_r <= parity_next_s;
`endif
        end
    end

    // FIFO storage; contents are only meaningful below the level count.
    always_ff @(posedge clk_in) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= tx_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
module tb_uart_tx_ctrl;

    localparam int CPB_A = 4;
    localparam int CPB_B = 2;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NBITS = 10 + PB;

    logic       clk = 1'b0;
    logic       arstn;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       uart_tx;
    logic       tx_busy;
    logic [2:0] fifo_level;

    logic [7:0] data_b;
    logic       valid_b;
    logic       ready_b;
    logic       line_b;
    logic       busy_b;
    logic [2:0] level_b;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // Behavioural model state: queued bytes, remaining per-cycle line values.
    logic [7:0] m_q[$];
    logic       m_rem[$];
    logic       m_line = 1'b1;
    logic       m_busy = 1'b0;

    always #5 clk = ~clk;

    uart_tx_ctrl #(.CLKS_PER_BIT(CPB_A), .FIFO_DEPTH(DEPTH)) dut_a (
        .clk_in(clk), .arstn(arstn), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .uart_tx(uart_tx), .tx_busy(tx_busy), .fifo_level(fifo_level)
    );

    uart_tx_ctrl #(.CLKS_PER_BIT(CPB_B), .FIFO_DEPTH(DEPTH)) dut_b (
        .clk_in(clk), .arstn(arstn), .tx_data(data_b), .tx_valid(valid_b),
        .tx_ready(ready_b), .uart_tx(line_b), .tx_busy(busy_b), .fifo_level(level_b)
    );

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare against the model, then advance the model for the next edge.
    initial begin
        logic [7:0] cur;
        logic       push;
        int         pre;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("model uart_tx", {7'd0, uart_tx}, {7'd0, m_line});
                chk("model tx_busy", {7'd0, tx_busy}, {7'd0, m_busy});
                chk("model fifo_level", {5'd0, fifo_level}, 8'(m_q.size()));
                chk("model tx_ready", {7'd0, tx_ready},
                    {7'd0, (arstn === 1'b1) && (m_q.size() != DEPTH)});
            end
            if (arstn !== 1'b1) begin
                m_q.delete();
                m_rem.delete();
                m_line = 1'b1;
                m_busy = 1'b0;
            end else begin
                pre  = m_q.size();
                push = (tx_valid === 1'b1) && (pre != DEPTH);
                if (m_rem.size() == 0 && pre > 0) begin
                    cur = m_q.pop_front();
                    for (int k = 0; k < NBITS; k++) begin
                        logic b;
                        if (k == 0)                 b = 1'b0;
                        else if (k <= 8)            b = cur[k-1];
                        else if (PB == 1 && k == 9) b = ^cur;
                        else                        b = 1'b1;
                        repeat (CPB_A) m_rem.push_back(b);
                    end
                end
                if (push) m_q.push_back(tx_data);
                if (m_rem.size() > 0) begin
                    m_line = m_rem.pop_front();
                    m_busy = 1'b1;
                end else begin
                    m_line = 1'b1;
                    m_busy = 1'b0;
                end
            end
        end
    end

    // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
    task automatic push_a(input logic [7:0] d);
        int   n;
        logic r;
        tx_data  = d;
        tx_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            r = tx_ready;
            @(posedge clk);
            #1;
            n++;
        end while (r !== 1'b1 && n < 500);
        tx_valid = 1'b0;
        if (r !== 1'b1) chk("push_a timeout", 8'd1, 8'd0);
    endtask

    task automatic push_b(input logic [7:0] d);
        int   n;
        logic r;
        data_b  = d;
        valid_b = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            r = ready_b;
            @(posedge clk);
            #1;
            n++;
        end while (r !== 1'b1 && n < 500);
        valid_b = 1'b0;
        if (r !== 1'b1) chk("push_b timeout", 8'd1, 8'd0);
    endtask

    task automatic wait_idle_a();
        int n;
        n = 0;
        while ((tx_busy !== 1'b0 || fifo_level !== 3'd0) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("idle wait timeout", {7'd0, n >= 3000}, 8'd0);
    endtask

    // Push one byte into an idle DUT and check its frame against a literal.
    task automatic frame_a(input logic [7:0] d, input logic [10:0] seq, input string nm);
        push_a(d);
        @(negedge clk);
        for (int i = 0; i < NBITS * CPB_A; i++) begin
            @(negedge clk);
            chk(nm, {7'd0, uart_tx}, {7'd0, seq[i / CPB_A]});
        end
        @(negedge clk);
        chk({nm, " busy after frame"}, {7'd0, tx_busy}, 8'd0);
        chk({nm, " idle line"}, {7'd0, uart_tx}, 8'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [10:0] seq_a5;
        logic [10:0] seq_07;
        logic [21:0] seq_b;
        int          n;

`ifdef UART_TX_PARITY_EN
        seq_a5 = 11'b10100101010;
        seq_07 = 11'b11000001110;
        seq_b  = 22'b10000000000_10111111110;
`else
        seq_a5 = 11'b01101001010;
        seq_07 = 11'b01000001110;
        seq_b  = 22'b00_1000000000_1111111110;
`endif

        arstn    = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        data_b   = 8'h00;
        valid_b  = 1'b0;

        @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("reset uart_tx", {7'd0, uart_tx}, 8'd1);
        chk("reset tx_busy", {7'd0, tx_busy}, 8'd0);
        chk("reset fifo_level", {5'd0, fifo_level}, 8'd0);
        chk("reset tx_ready", {7'd0, tx_ready}, 8'd0);
        @(posedge clk);
        #1;
        arstn = 1'b1;
        @(posedge clk);
        #1;
        chk("ready after release", {7'd0, tx_ready}, 8'd1);

        // Single byte frames with literal expectations.
        frame_a(8'hA5, seq_a5, "frame 0xA5");
        frame_a(8'h07, seq_07, "frame 0x07");

        // FIFO fill: 0x05 brings the level to full, 0x06 is held off.
        push_a(8'h01);
        push_a(8'h02);
        push_a(8'h03);
        push_a(8'h04);
        push_a(8'h05);
        chk("fill level", {5'd0, fifo_level}, 8'd4);
        chk("fill ready", {7'd0, tx_ready}, 8'd0);
        push_a(8'h06);
        wait_idle_a();

        // Push coinciding with the STOP->START pop at level 2.
        push_a(8'h5A);
        push_a(8'hC3);
        push_a(8'h96);
        n = 0;
        while (!(m_busy && m_rem.size() == 0) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("boundary wait timeout", {7'd0, n >= 200}, 8'd0);
        chk("boundary level before", {5'd0, fifo_level}, 8'd2);
        tx_data  = 8'h4B;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        tx_data  = 8'hFF;
        chk("boundary level after", {5'd0, fifo_level}, 8'd2);
        wait_idle_a();

        // Reset ten cycles into a frame with two bytes queued.
        push_a(8'h3C);
        push_a(8'h11);
        push_a(8'h22);
        repeat (8) @(posedge clk);
        #1;
        arstn = 1'b0;
        @(posedge clk);
        #1;
        chk("midreset uart_tx", {7'd0, uart_tx}, 8'd1);
        chk("midreset fifo_level", {5'd0, fifo_level}, 8'd0);
        chk("midreset tx_busy", {7'd0, tx_busy}, 8'd0);
        chk("midreset tx_ready", {7'd0, tx_ready}, 8'd0);
        repeat (2) @(posedge clk);
        #1;
        arstn = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        chk("post reset no frame", {7'd0, tx_busy}, 8'd0);
        frame_a(8'hA5, seq_a5, "frame after reset");

        // Two cycles per bit: 0xFF then 0x00 back-to-back.
        push_b(8'hFF);
        push_b(8'h00);
        for (int i = 0; i < 2 * NBITS * CPB_B; i++) begin
            @(negedge clk);
            chk("cpb2 line", {7'd0, line_b}, {7'd0, seq_b[i / CPB_B]});
        end
        @(negedge clk);
        chk("cpb2 busy end", {7'd0, busy_b}, 8'd0);
        chk("cpb2 idle line", {7'd0, line_b}, 8'd1);

        @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
